// File: rtl/bcd_line_formatter_uart_if.sv
// Handshake bundle between the BCD reading source, the line formatter and the
// byte-wide UART transmitter.
interface bcd_line_formatter_uart_if #(
   parameter int NUMBER_OF_DIGITS = 8
);
   logic [4*NUMBER_OF_DIGITS-1:0] bcd_in;
   logic                          bcd_valid;
   logic                          uart_busy;
   logic                          uart_start;
   logic [7:0]                    uart_byte;
   logic                          line_active;
   logic                          dropped;

   modport master (
      output bcd_in, bcd_valid, uart_busy,
      input  uart_start, uart_byte, line_active, dropped
   );

   modport slave (
      input  bcd_in, bcd_valid, uart_busy,
      output uart_start, uart_byte, line_active, dropped
   );
endinterface

// File: rtl/bcd_line_formatter_uart.sv
// Turns packed-BCD readings into fixed-width ASCII lines (blanked, '.', CR LF)
// and feeds them one byte at a time to the UART, with a one-entry pending buffer.
module bcd_line_formatter_uart #(
   parameter int NUMBER_OF_DIGITS       = 8,
   parameter int DECIMAL_POINT_POSITION = 2,
   parameter bit SUPPRESS_REPEATS       = 1'b1
) (
   input logic                      clock,
   input logic                      resetb,
   bcd_line_formatter_uart_if.slave bus
);
   localparam int ND  = NUMBER_OF_DIGITS;
   localparam int DP  = DECIMAL_POINT_POSITION;
   localparam int W   = 4 * ND;
   localparam int LEN = ND + ((DP > 0) ? 1 : 0) + 2;
   localparam logic [4:0] IDX_DOT = 5'(ND - DP);
   localparam logic [4:0] IDX_CR  = 5'(LEN - 2);
   localparam logic [4:0] IDX_LF  = 5'(LEN - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_SETTLE, S_DRAIN} state_t;

   state_t       state_q, state_d;
   logic [W-1:0] line_q, line_d;
   logic [W-1:0] pend_q, pend_d;
   logic [W-1:0] last_q, last_d;
   logic         pend_full_q, pend_full_d;
   logic [4:0]   idx_q, idx_d;
   logic         start_q, start_d;
   logic [7:0]   byte_q, byte_d;
   logic         dropped_q, dropped_d;

   logic [W-1:0] cand;
   logic         pend_take, to_pend, avail, repeat_hit;
   logic [4:0]   dsel;
   logic [3:0]   dig;
   logic         allz, blank;
   logic [7:0]   ch;

   // Character for the current index; a zero digit is blanked only while every
   // digit up to and including it is zero and it sits left of the units digit.
   always_comb begin
      dsel = idx_q;
      if (DP > 0 && idx_q > IDX_DOT) dsel = idx_q - 5'd1;
      dig   = 4'h0;
      blank = 1'b0;
      allz  = 1'b1;
      for (int unsigned i = 0; i < ND; i++) begin
         allz = allz && (line_q[4*(ND-1-i) +: 4] == 4'h0);
         if (dsel == 5'(i)) begin
            dig   = line_q[4*(ND-1-i) +: 4];
            blank = allz && (i + 1 < ND - DP);
         end
      end
      if (idx_q == IDX_CR)                    ch = 8'h0d;
      else if (idx_q == IDX_LF)               ch = 8'h0a;
      else if (DP > 0 && idx_q == IDX_DOT)    ch = 8'h2e;
      else if (blank)                         ch = 8'h20;
      else if (dig > 4'd9)                    ch = 8'h3f;
      else                                    ch = {4'h3, dig};
   end

   always_comb begin
      state_d     = state_q;
      line_d      = line_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      last_d      = last_q;
      idx_d       = idx_q;
      start_d     = 1'b0;
      byte_d      = byte_q;
      dropped_d   = 1'b0;

      pend_take  = (state_q == S_IDLE) && pend_full_q;
      to_pend    = bus.bcd_valid && ((state_q != S_IDLE) || pend_full_q);
      cand       = pend_full_q ? pend_q : bus.bcd_in;
      avail      = pend_full_q || bus.bcd_valid;
      repeat_hit = SUPPRESS_REPEATS && (cand == last_q);

      if (pend_take) pend_full_d = 1'b0;
      if (to_pend) begin
         pend_d      = bus.bcd_in;
         pend_full_d = 1'b1;
         dropped_d   = pend_full_q && !pend_take;
      end

      unique case (state_q)
         S_IDLE: begin
            if (avail && !repeat_hit) begin
               state_d = S_LOAD;
               line_d  = cand;
               last_d  = cand;
               idx_d   = '0;
            end
         end
         // The first strobe is pre-issued from LOAD so it lands in the first
         // ISSUE cycle; later bytes raise start from inside ISSUE.
         S_LOAD: begin
            state_d = S_ISSUE;
            if (!bus.uart_busy) begin
               start_d = 1'b1;
               byte_d  = ch;
            end
         end
         S_ISSUE: begin
            if (start_q) begin
               state_d = S_SETTLE;
            end else if (!bus.uart_busy) begin
               start_d = 1'b1;
               byte_d  = ch;
            end
         end
         S_SETTLE: state_d = S_DRAIN;
         S_DRAIN: begin
            if (!bus.uart_busy) begin
               if (idx_q == IDX_LF) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = S_ISSUE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q     <= S_IDLE;
         line_q      <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         last_q      <= '1;
         idx_q       <= '0;
         start_q     <= 1'b0;
         byte_q      <= '0;
         dropped_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         line_q      <= line_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         last_q      <= last_d;
         idx_q       <= idx_d;
         start_q     <= start_d;
         byte_q      <= byte_d;
         dropped_q   <= dropped_d;
      end
   end

   assign bus.uart_start  = start_q;
   assign bus.uart_byte   = byte_q;
   assign bus.line_active = (state_q != S_IDLE);
   assign bus.dropped     = dropped_q;
endmodule
